frame_serial_tx: RTL
====================

Name: frame_serial_tx

Overview:
- Byte-framed serial transmitter: the sending end of the corpus serial-frame interface, paired with the frame receiver.
- Accepts parallel words over a valid/ready handshake.
- Emits start bit, LSB-first data, optional even parity and stop bit on a single line, paced by a bit-period counter.
- Types and constants come from a shared package through explicit and wildcard imports, so the block also exercises package search order in elaboration.

Parameters:
- DATA_W, 8, data bits per frame (1..16)
- CLKS_PER_BIT, 4, clock cycles per serial bit (>=2)
- PARITY_EN, 1, 1 = append even parity bit; 0 = no parity bit

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  word to transmit
- tx_line  output  1  serial line, idle high
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset values (applied at the clk edge while rst=1): state=IDLE, tx_line=1, in_ready=1, busy=0, frame_done=0, counters=0, shift register=0.
- in_ready = (state==IDLE). Handshake: a word is accepted when in_valid && in_ready at a clk edge. in_data is captured into a shift register and parity is computed as the XOR of the captured bits.
- Accept in cycle N: tx_line=0 (START) from cycle N+1 for CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE: on accept, go to START.
  - START: when bit period ends, go to DATA.
  - DATA: after DATA_W bit periods, go to PARITY if PARITY_EN, else STOP.
  - PARITY: when bit period ends, go to STOP.
  - STOP: when bit period ends, go to IDLE.
- Line value per state: START=0; DATA=shift[0], shifting right at each bit end; PARITY=even-parity bit; STOP=1; IDLE=1.
- Bit timer: counts 0..CLKS_PER_BIT-1. bit_end is asserted when the count equals CLKS_PER_BIT-1, then the count wraps to 0. Timer is held at 0 in IDLE.
- Data bit index: width $clog2(DATA_W+1). It increments on each DATA bit_end, and DATA exits when index == DATA_W-1 at bit_end.
- frame_done is high exactly during the final cycle of STOP. busy is high in every state except IDLE.
- Frame length: (1+DATA_W+PARITY_EN+1)*CLKS_PER_BIT cycles. No back-to-back overlap: in_ready returns high the cycle after the STOP bit ends, so the minimum inter-frame gap is 1 IDLE cycle.
- in_valid while busy is ignored; in_data is not sampled.
- rst mid-frame: on the next edge the block returns to IDLE with tx_line=1 and no frame_done. The partial word is dropped.
- rst and in_valid asserted together: reset wins and nothing is accepted.
- All-ones and all-zeros data must serialize correctly; with PARITY_EN=1, parity=0 for both when DATA_W is even.

Decomposition:
- Package frame_serial_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - typedef enum logic {FALSE, TRUE} bool_t
  - parameter int IDLE_LEVEL = 1
  - parameter int START_LEVEL = 0
- Import rules:
  - The module imports tx_state_t explicitly and the remainder by wildcard.
  - No local declaration may reuse a package name; this keeps wildcard ambiguity out of the design.
- Sub-module frame_serial_bit_timer: CLKS_PER_BIT parameter; inputs clk, rst, run; output bit_end. The counter is cleared whenever run=0.

Test Plan:
- Reset, DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1 -> tx_line=1, in_ready=1, busy=0, frame_done=0 for 10 idle cycles.
- Send 0xA5 -> line bits 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop), each held 4 cycles; frame_done in cycle 44 after accept; in_ready high the cycle after.
- Send 0x01 then 0xFF with in_valid held high -> second accepted exactly 1 cycle after the first frame's stop ends; parity bits 1 then 0.
- PARITY_EN=0, send 0x80 -> 10-bit frame of 40 cycles, data bits 0,0,0,0,0,0,0,1, no parity slot.
- Assert rst for 1 cycle during data bit 3 of 0x3C -> tx_line=1 and in_ready=1 next cycle, no frame_done; a following 0x55 transmits cleanly.
- in_valid pulsed with 0x99 while busy -> ignored; the line carries only the original frame.

Source files
------------

// File: rtl/frame_serial_pkg.sv
// Shared types and line levels for the serial-frame transmitter.
package frame_serial_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    typedef enum logic {FALSE, TRUE} bool_t;

    parameter int IDLE_LEVEL  = 1;
    parameter int START_LEVEL = 0;

endpackage

// File: rtl/frame_serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, flags the last cycle.
module frame_serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Free-running within a frame; held at zero whenever the transmitter is idle.
    always_ff @(posedge clk) begin
        if (rst || !run)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign bit_end = run && (cnt == LAST);

endmodule

// File: rtl/frame_serial_tx.sv
// Byte-framed serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
module frame_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_line,
    output logic              busy,
    output logic              frame_done
);

    import frame_serial_pkg::tx_state_t;
    import frame_serial_pkg::*;

    localparam int    IW         = $clog2(DATA_W + 1);
    localparam bool_t HAS_PARITY = (PARITY_EN != 0) ? TRUE : FALSE;

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift;
    logic              par;
    logic [IW-1:0]     bit_idx;
    logic              bit_end;
    logic              accept;
    logic              last_data;

    assign accept    = in_valid && (state == IDLE);
    assign last_data = (bit_idx == IW'(DATA_W - 1));

    frame_serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state != IDLE),
        .bit_end (bit_end)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: every non-idle state advances only on a bit boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && last_data)
                         state_nxt = (HAS_PARITY == TRUE) ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture word and its parity on accept, shift out LSB-first, track data bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= '0;
            par     <= 1'b0;
            bit_idx <= '0;
        end else begin
            if (accept) begin
                shift <= in_data;
                par   <= ^in_data;
            end else if (state == DATA && bit_end) begin
                shift <= shift >> 1;
            end
            if (state != DATA)
                bit_idx <= '0;
            else if (bit_end)
                bit_idx <= bit_idx + 1'b1;
        end
    end

    // Outputs decoded from state; the line idles high and frame_done marks the final stop cycle.
    always_comb begin
        tx_line    = 1'(IDLE_LEVEL);
        in_ready   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            START:   tx_line    = 1'(START_LEVEL);
            DATA:    tx_line    = shift[0];
            PARITY:  tx_line    = par;
            STOP:    frame_done = bit_end;
            default: ;
        endcase
    end

endmodule
